// File: rtl/grass_pkg.sv
// grass_pkg: shared constants, FSM state type and a small modulo helper for
// the scrolling ground-band controller.
//   TILE_W/TILE_H  : ground tile size in pixels
//   BAND_Y0        : first screen row of the ground band
//   ADDR_W/DATA_W  : sprite-ROM address and pixel widths
//   PIX_W/COL_W    : pixel coordinate and tile column/offset widths
package grass_pkg;

  localparam int TILE_W  = 20;
  localparam int TILE_H  = 20;
  localparam int BAND_Y0 = 440;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
  localparam int PIX_W   = 10;
  localparam int COL_W   = 5;

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_SCROLLING,
    ST_DRAINING
  } grass_state_t;

  // Add two values that are each below TILE_W and fold the result back into
  // 0..TILE_W-1 with a single compare-and-subtract instead of a divider.
  function automatic logic [COL_W-1:0] wrapAdd(input logic [COL_W-1:0] base,
                                               input logic [COL_W-1:0] inc);
    logic [COL_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum >= (COL_W+1)'(TILE_W)) begin
      sum = sum - (COL_W+1)'(TILE_W);
    end
    return sum[COL_W-1:0];
  endfunction

endpackage

// File: rtl/grass_scroll_ctrl_if.sv
// grass_scroll_ctrl_if: groups the pixel stream, ROM port, mixer output and
// status signals of the ground-band controller.
//   run, frame_start            : scroll control (master -> slave)
//   pix_valid, pix_x, pix_y     : VGA pixel stream (master -> slave)
//   rom_addr / rom_data         : tile ROM port (slave drives the address)
//   pix_out_valid, pix_out,
//   pix_out_in_band             : aligned ground pixel for the mixer
//   scroll_pos, stopped         : status
// The controller connects through the slave modport.
interface grass_scroll_ctrl_if;
  import grass_pkg::*;

  logic              run;
  logic              frame_start;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_x;
  logic [PIX_W-1:0]  pix_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              pix_out_valid;
  logic [DATA_W-1:0] pix_out;
  logic              pix_out_in_band;
  logic [COL_W-1:0]  scroll_pos;
  logic              stopped;

  modport master (
    output run, frame_start, pix_valid, pix_x, pix_y, rom_data,
    input  rom_addr, pix_out_valid, pix_out, pix_out_in_band, scroll_pos, stopped
  );

  modport slave (
    input  run, frame_start, pix_valid, pix_x, pix_y, rom_data,
    output rom_addr, pix_out_valid, pix_out, pix_out_in_band, scroll_pos, stopped
  );

endinterface

// File: rtl/grass_tile_addr_gen.sv
// grass_tile_addr_gen: first pipeline stage of the ground band. Tracks the
// tile column along a line, decides whether the row lies in the band and
// registers the ROM address.
//   clka, rsta        : clock, synchronous active-high reset
//   i_pix_valid/x/y   : pixel stream
//   i_offset          : current scroll offset, latched at each line start
//   o_rom_addr        : registered ROM address (0 when idle or out of band)
//   o_valid           : a pixel was sampled in the previous cycle
//   o_in_band         : that pixel lies in the ground band
module grass_tile_addr_gen
  import grass_pkg::*;
(
  input  logic              clka,
  input  logic              rsta,
  input  logic              i_pix_valid,
  input  logic [PIX_W-1:0]  i_pix_x,
  input  logic [PIX_W-1:0]  i_pix_y,
  input  logic [COL_W-1:0]  i_offset,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_valid,
  output logic              o_in_band
);

  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_romAddr;
  logic              r_valid;
  logic              r_inBand;

  logic [COL_W-1:0]  w_col;
  logic              w_inBand;
  logic [COL_W-1:0]  w_row;
  logic [ADDR_W-1:0] w_rowExt;
  logic [ADDR_W-1:0] w_addr;

  // The offset is only looked at on the first pixel of a line, so a scroll
  // update can never disturb a line that is already being drawn.
  assign w_col = (i_pix_x == '0) ? i_offset : wrapAdd(r_col, COL_W'(1));

  // Compare before subtracting so rows above the band cannot wrap into it.
  assign w_inBand = (i_pix_y >= PIX_W'(BAND_Y0)) &&
                    (i_pix_y <  PIX_W'(BAND_Y0 + TILE_H));
  assign w_row    = COL_W'(i_pix_y - PIX_W'(BAND_Y0));
  assign w_rowExt = ADDR_W'(w_row);

  // row*20 as row*16 + row*4.
  assign w_addr = (w_rowExt << 4) + (w_rowExt << 2) + ADDR_W'(w_col);

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_col     <= '0;
      r_romAddr <= '0;
      r_valid   <= 1'b0;
      r_inBand  <= 1'b0;
    end else begin
      if (i_pix_valid) begin
        r_col <= w_col;
      end
      r_valid   <= i_pix_valid;
      r_inBand  <= i_pix_valid && w_inBand;
      r_romAddr <= (i_pix_valid && w_inBand) ? w_addr : '0;
    end
  end

  assign o_rom_addr = r_romAddr;
  assign o_valid    = r_valid;
  assign o_in_band  = r_inBand;

endmodule

// File: rtl/grass_scroll_ctrl.sv
// grass_scroll_ctrl: scrolling ground-band controller for the Flappy Bird
// display. Tiles the 20x20 ground ROM across the band, advances the scroll
// offset once per frame and parks on a tile-aligned offset when stopping.
//   clka   : pixel clock
//   rsta   : synchronous active-high reset
//   bus    : slave side of grass_scroll_ctrl_if (pixel stream, ROM port,
//            mixer output, scroll_pos/stopped status)
//   SPEED  : scroll pixels per frame, 1..TILE_W-1
// Output pixels appear two cycles after the input pixel: one cycle for the
// registered address, one for the synchronous ROM read.
module grass_scroll_ctrl
  import grass_pkg::*;
#(
  parameter int SPEED = 2
) (
  input logic               clka,
  input logic               rsta,
  grass_scroll_ctrl_if.slave bus
);

  grass_state_t     r_state;
  logic [COL_W-1:0] r_offset;
  logic             r_stopped;
  logic             r_outValid;
  logic             r_outBand;

  logic [COL_W:0]   w_advSum;
  logic             w_overshoot;
  logic [COL_W-1:0] w_advWrapped;
  logic             w_stage1Valid;
  logic             w_stage1Band;

  assign w_advSum     = {1'b0, r_offset} + (COL_W+1)'(SPEED);
  assign w_overshoot  = (w_advSum >= (COL_W+1)'(TILE_W));
  assign w_advWrapped = wrapAdd(r_offset, COL_W'(SPEED));

  // Run/stop state machine. Draining keeps advancing but lands on offset 0
  // instead of wrapping past it, so the ground parks tile-aligned.
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state   <= ST_STOPPED;
      r_offset  <= '0;
      r_stopped <= 1'b1;
    end else if (bus.frame_start) begin
      case (r_state)
        ST_STOPPED: begin
          if (bus.run) begin
            r_state   <= ST_SCROLLING;
            r_stopped <= 1'b0;
          end
        end
        ST_SCROLLING: begin
          r_offset <= w_advWrapped;
          if (!bus.run) begin
            r_state <= ST_DRAINING;
          end
        end
        ST_DRAINING: begin
          if (bus.run) begin
            r_state  <= ST_SCROLLING;
            r_offset <= w_advWrapped;
          end else if (w_overshoot) begin
            r_state   <= ST_STOPPED;
            r_offset  <= '0;
            r_stopped <= 1'b1;
          end else begin
            r_offset <= w_advWrapped;
          end
        end
        default: begin
          r_state   <= ST_STOPPED;
          r_offset  <= '0;
          r_stopped <= 1'b1;
        end
      endcase
    end
  end

  grass_tile_addr_gen u_addr_gen (
    .clka       (clka),
    .rsta       (rsta),
    .i_pix_valid(bus.pix_valid),
    .i_pix_x    (bus.pix_x),
    .i_pix_y    (bus.pix_y),
    .i_offset   (r_offset),
    .o_rom_addr (bus.rom_addr),
    .o_valid    (w_stage1Valid),
    .o_in_band  (w_stage1Band)
  );

  // Delay the flags one more cycle to line up with the ROM read data.
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_outValid <= 1'b0;
      r_outBand  <= 1'b0;
    end else begin
      r_outValid <= w_stage1Valid;
      r_outBand  <= w_stage1Band;
    end
  end

  assign bus.pix_out_valid   = r_outValid;
  assign bus.pix_out_in_band = r_outBand;
  assign bus.pix_out         = r_outBand ? bus.rom_data : '0;
  assign bus.scroll_pos      = r_offset;
  assign bus.stopped         = r_stopped;

endmodule

// File: tb/tb_grass_scroll_ctrl.sv
// tb_grass_scroll_ctrl: drives pixel lines and frame pulses into
// grass_scroll_ctrl and compares every cycle against a reference model that
// computes columns with modulo arithmetic and the offset from the run/stop
// rules. A randomly filled ROM array answers the ROM port.
module tb_grass_scroll_ctrl;
  import grass_pkg::*;

  localparam int SPEED = 2;

  typedef struct {
    bit valid;
    bit inBand;
    int addr;
  } pixExp_t;

  logic clka = 1'b0;
  logic rsta;

  always #5 clka = ~clka;

  grass_scroll_ctrl_if bus();

  grass_scroll_ctrl #(.SPEED(SPEED)) dut (
    .clka(clka),
    .rsta(rsta),
    .bus (bus)
  );

  logic [DATA_W-1:0] rom [0:511];

  always @(posedge clka) begin
    bus.rom_data <= rom[bus.rom_addr];
  end

  int      testsRun;
  int      testsFailed;
  int      mOffset;
  bit      mStopped;
  bit      mDraining;
  int      lineOff;
  pixExp_t stage1;
  pixExp_t stage2;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelFrame(input bit runLvl);
    int nxt;
    nxt = mOffset + SPEED;
    if (mStopped) begin
      if (runLvl) mStopped = 1'b0;
    end else if (!mDraining) begin
      mOffset = nxt % TILE_W;
      if (!runLvl) mDraining = 1'b1;
    end else if (runLvl) begin
      mDraining = 1'b0;
      mOffset   = nxt % TILE_W;
    end else if (nxt >= TILE_W) begin
      mOffset   = 0;
      mStopped  = 1'b1;
      mDraining = 1'b0;
    end else begin
      mOffset = nxt;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit fs, input bit runLvl,
                               input bit v, input int x, input int y);
    pixExp_t cur;
    rsta            = rst;
    bus.frame_start = fs;
    bus.run         = runLvl;
    bus.pix_valid   = v;
    bus.pix_x       = PIX_W'(x);
    bus.pix_y       = PIX_W'(y);
    if (v && x == 0) lineOff = mOffset;
    cur.valid  = v;
    cur.inBand = v && (y >= BAND_Y0) && (y < BAND_Y0 + TILE_H);
    cur.addr   = cur.inBand ? (y - BAND_Y0) * TILE_W + (lineOff + x) % TILE_W : 0;
    @(posedge clka);
    #1;
    if (rst) begin
      mOffset   = 0;
      mStopped  = 1'b1;
      mDraining = 1'b0;
      lineOff   = 0;
      stage1    = '{1'b0, 1'b0, 0};
      stage2    = '{1'b0, 1'b0, 0};
    end else begin
      if (fs) modelFrame(runLvl);
      stage2 = stage1;
      stage1 = cur;
    end
    checkOutput("rom_addr", 32'(bus.rom_addr), stage1.addr);
    checkOutput("pix_out_valid", 32'(bus.pix_out_valid), 32'(stage2.valid));
    checkOutput("pix_out_in_band", 32'(bus.pix_out_in_band), 32'(stage2.inBand));
    checkOutput("pix_out", 32'(bus.pix_out), stage2.inBand ? 32'(rom[stage2.addr]) : 0);
    checkOutput("scroll_pos", 32'(bus.scroll_pos), mOffset);
    checkOutput("stopped", 32'(bus.stopped), 32'(mStopped));
  endtask

  task automatic frameTick(input bit runLvl);
    applyStimulus(1'b0, 1'b1, runLvl, 1'b0, 0, 0);
  endtask

  task automatic driveLine(input int y, input int len, input int fsAt, input bit runLvl,
                           input int chkX1, input int chkA1, input int chkX2, input int chkA2);
    for (int x = 0; x < len; x++) begin
      applyStimulus(1'b0, x == fsAt, runLvl, 1'b1, x, y);
      if (x == chkX1) checkOutput("directed_addr_a", 32'(bus.rom_addr), chkA1);
      if (x == chkX2) checkOutput("directed_addr_b", 32'(bus.rom_addr), chkA2);
    end
    applyStimulus(1'b0, 1'b0, runLvl, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, runLvl, 1'b0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    int fsAt;
    bit runLvl;
    bit reached;
    testsRun    = 0;
    testsFailed = 0;
    for (int i = 0; i < 512; i++) rom[i] = DATA_W'($urandom);
    mOffset   = 0;
    mStopped  = 1'b1;
    mDraining = 1'b0;
    lineOff   = 0;
    stage1    = '{1'b0, 1'b0, 0};
    stage2    = '{1'b0, 1'b0, 0};

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("reset_scroll_pos", 32'(bus.scroll_pos), 0);
    checkOutput("reset_stopped", 32'(bus.stopped), 1);
    checkOutput("reset_out_valid", 32'(bus.pix_out_valid), 0);

    for (int f = 0; f < 3; f++) begin
      frameTick(1'b0);
      checkOutput("idle_scroll_pos", 32'(bus.scroll_pos), 0);
      checkOutput("idle_stopped", 32'(bus.stopped), 1);
    end
    driveLine(445, 30, -1, 1'b0, 0, 100, 21, 101);

    frameTick(1'b1);
    checkOutput("enter_scroll_pos", 32'(bus.scroll_pos), 0);
    checkOutput("enter_stopped", 32'(bus.stopped), 0);
    for (int f = 1; f <= 10; f++) begin
      if (mOffset == 6) driveLine(440, 30, -1, 1'b1, 0, 6, 14, 0);
      else driveLine($urandom_range(430, 465), $urandom_range(20, 45), -1, 1'b1, -1, 0, -1, 0);
      frameTick(1'b1);
      checkOutput("scroll_seq", 32'(bus.scroll_pos), (2 * f) % TILE_W);
    end

    for (int f = 0; f < 7; f++) frameTick(1'b1);
    checkOutput("pre_drain_pos", 32'(bus.scroll_pos), 14);
    frameTick(1'b0);
    checkOutput("drain_pos_16", 32'(bus.scroll_pos), 16);
    checkOutput("drain_not_stopped", 32'(bus.stopped), 0);
    frameTick(1'b0);
    checkOutput("drain_pos_18", 32'(bus.scroll_pos), 18);
    frameTick(1'b0);
    checkOutput("drain_pos_0", 32'(bus.scroll_pos), 0);
    checkOutput("drain_stopped", 32'(bus.stopped), 1);

    driveLine(439, 25, -1, 1'b0, -1, 0, -1, 0);
    driveLine(460, 25, -1, 1'b0, -1, 0, -1, 0);
    driveLine(459, 25, -1, 1'b0, 19, 399, -1, 0);

    frameTick(1'b1);
    frameTick(1'b1);
    frameTick(1'b0);
    checkOutput("redrain_pos", 32'(bus.scroll_pos), 4);
    frameTick(1'b1);
    checkOutput("resume_pos", 32'(bus.scroll_pos), 6);
    checkOutput("resume_stopped", 32'(bus.stopped), 0);
    frameTick(1'b1);
    checkOutput("resume_pos_next", 32'(bus.scroll_pos), 8);

    driveLine(450, 320, 300, 1'b1, 301, 209, -1, 0);
    driveLine(451, 40, -1, 1'b1, 0, 230, -1, 0);

    for (int it = 0; it < 60; it++) begin
      runLvl = 1'($urandom_range(0, 1));
      len    = $urandom_range(20, 50);
      fsAt   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      driveLine($urandom_range(425, 470), len, fsAt, runLvl, -1, 0, -1, 0);
      if ($urandom_range(0, 1) == 1) frameTick(runLvl);
    end

    reached = 1'b0;
    for (int f = 0; f < 40 && !reached; f++) begin
      if (mOffset == 10 && !mStopped && !mDraining) reached = 1'b1;
      else frameTick(1'b1);
    end
    checkOutput("reach_offset_10", 32'(bus.scroll_pos), 10);
    for (int x = 0; x < 6; x++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, x, 445);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 6, 445);
    checkOutput("midreset_out_valid", 32'(bus.pix_out_valid), 0);
    checkOutput("midreset_rom_addr", 32'(bus.rom_addr), 0);
    checkOutput("midreset_pix_out", 32'(bus.pix_out), 0);
    checkOutput("midreset_stopped", 32'(bus.stopped), 1);
    checkOutput("midreset_scroll_pos", 32'(bus.scroll_pos), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("inflight_cleared_1", 32'(bus.pix_out_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("inflight_cleared_2", 32'(bus.pix_out_valid), 0);
    driveLine(445, 30, -1, 1'b0, 0, 100, 21, 101);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
